mem_byte_arbiter: RTL and testbench
===================================

Name: mem_byte_arbiter

Overview:
- Shares the single 8-bit, 1536-byte block-RAM port between two requesters: instruction fetch (read-only, 32-bit) and load/store (read/write; byte, half or word).
- Serialises each access into little-endian byte beats and assembles read data into a 32-bit response.
- Sits between the core's fetch/LSU and the banked RAM wrapper.

Parameters:
RD_LAT, 1, RAM read latency in cycles from RE_c beat to valid ram_rdata
MEM_BYTES, 1536, addressable bytes; any beat at or above this address is out of range
AW, 11, RAM byte-address width

Ports:
CLK_c  in  1  single clock; all logic on its posedge
RST_N_c  in  1  reset, synchronous, active-low
if_req  in  1  fetch request; held until if_done
if_addr  in  AW  fetch byte address (word read)
if_done  out  1  one-cycle completion pulse to fetch
if_rdata  out  32  fetch data; valid while if_done=1
if_err  out  1  out-of-range flag; valid while if_done=1
ls_req  in  1  LSU request; held until ls_done
ls_we  in  1  1=write, 0=read
ls_size  in  2  00 byte, 01 half, 10 word, 11 illegal
ls_addr  in  AW  LSU byte address
ls_wdata  in  32  write data; byte k goes to addr+k
ls_done  out  1  one-cycle completion pulse to LSU
ls_rdata  out  32  read data, zero-extended; valid while ls_done=1
ls_err  out  1  error flag; valid while ls_done=1
ram_raddr  out  AW  RAM read address
ram_re  out  1  RAM read enable
ram_waddr  out  AW  RAM write address
ram_we  out  1  RAM write enable
ram_wdata  out  8  RAM write byte
ram_rdata  in  8  RAM read byte

Behaviour:
- Reset (RST_N_c=0 at a posedge): state IDLE; all outputs 0; last-grant = fetch. Reset mid-access aborts it: no done pulse, RE/WE low from the next cycle.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE: sample requests. Both asserted -> round-robin (grant the requester not granted last); one asserted -> grant it.
  - Latch the granted addr, size, we and wdata.
  - Beat count N: 4 for fetch; 1/2/4 for ls_size 00/01/10.
  - Check range with AW+1-bit arithmetic: addr+N-1 >= MEM_BYTES, or ls_size=11, sets err.
  - err -> go to RESP directly; no RAM access is issued.
  - Otherwise -> ISSUE.
- ISSUE: one beat per cycle, beat k = 0..N-1, address = addr+k.
  - Read: ram_re=1, ram_raddr=addr+k.
  - Write: ram_we=1, ram_waddr=addr+k, ram_wdata=wdata[8k+7:8k].
  - After the last beat: read -> DRAIN; write -> RESP.
- DRAIN: the byte for beat k is captured RD_LAT cycles after its issue cycle into rdata[8k+7:8k]. After the last capture -> RESP.
- RESP: pulse done for exactly one cycle to the granted requester.
  - Present rdata; bytes above N are 0.
  - err response: rdata=0, err=1.
  - Update last-grant -> IDLE.
  - The requester must deassert or change its req in the cycle after done. A req still high in IDLE is a new access.
- Latency, with the accept cycle = 0:
  - Read: done at cycle N+RD_LAT+1 (word, RD_LAT=1 -> cycle 6).
  - Write: done at cycle N+1.
  - Error: done at cycle 1.
- Outside ISSUE, ram_re and ram_we stay 0. Read and write beats never occur in the same cycle.
- The non-granted requester sees done=0; its request waits without starvation. The maximum wait is one full access of the other port.
- Misaligned addresses are legal; only range crossing is an error.
- Changes to req, addr or data while an access is in flight are ignored. Sign extension is not done here; the LSU does it.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, MEM_BYTES constant.
- One natural sub-module, mem_beat_assembler: per-beat byte capture into the 32-bit word, with a capture counter delayed by RD_LAT.

Test Plan:
- Fetch-only word read, addr 0x010, RAM[0x10..0x13]=11,22,33,44 -> RE beats on addresses 0x10-0x13; if_done at cycle 6; if_rdata=0x44332211; if_err=0.
- LSU half write 0xBEEF at 0x5FE, then byte read at 0x5FF -> WE beats writing EF then BE; ls_done at cycle 3; the read returns ls_rdata=0x000000BE.
- Simultaneous if_req (addr 0x000) and ls_req (word read, addr 0x100) after reset -> LSU granted first (last-grant=fetch); fetch done follows; the next tie grants LSU again only if fetch was last.
- Range errors: LSU word read at 0x5FD -> ls_done at cycle 1, ls_err=1, ls_rdata=0, no RE. ls_size=11 -> same. Fetch at 0x5FC -> succeeds.
- Reset asserted during the ISSUE of a word write after 2 beats -> only 2 bytes written, no ls_done; after release all outputs are 0 and the next request completes normally.
- RD_LAT=2 variant: word read done at cycle 7 with correct byte order.

Source files
------------

// File: rtl/mem_byte_arbiter_pkg.sv
// Shared types and constants for the byte-serial RAM arbiter.
package mem_byte_arbiter_pkg;

  localparam int unsigned MEM_BYTES_C = 1536;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_RESP
  } state_t;

  // Number of byte beats for an access size (illegal sizes are flagged elsewhere).
  function automatic logic [2:0] beat_count(input size_t sz);
    case (sz)
      SZ_BYTE: beat_count = 3'd1;
      SZ_HALF: beat_count = 3'd2;
      default: beat_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_beat_assembler.sv
// Captures returning RAM bytes into a little-endian 32-bit word.
module mem_beat_assembler #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        CLK_c,
  input  logic        RST_N_c,
  input  logic        clr,
  input  logic        beat_re,
  input  logic [2:0]  n_beats,
  input  logic [7:0]  ram_rdata,
  output logic        last_cap,
  output logic [31:0] rdata
);

  logic [RD_LAT-1:0] issue_pipe;
  logic [1:0]        cap_cnt;
  logic              cap_vld;

  assign cap_vld = issue_pipe[RD_LAT-1];

  // Delay each issued read by RD_LAT and drop the returned byte into its lane.
  always_ff @(posedge CLK_c) begin
    if (!RST_N_c || clr) begin
      issue_pipe <= '0;
      cap_cnt    <= '0;
      rdata      <= '0;
    end else begin
      issue_pipe[0] <= beat_re;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        issue_pipe[i] <= issue_pipe[i-1];
      end
      if (cap_vld) begin
        rdata[{cap_cnt, 3'b000} +: 8] <= ram_rdata;
        cap_cnt                       <= cap_cnt + 2'd1;
      end
    end
  end

  // Flag the capture of the final byte of the access.
  always_comb begin
    last_cap = cap_vld && ({1'b0, cap_cnt} == (n_beats - 3'd1));
  end

endmodule

// File: rtl/mem_byte_arbiter.sv
// Arbitrates fetch and load/store onto a single byte-wide RAM port.
module mem_byte_arbiter
  import mem_byte_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MEM_BYTES = MEM_BYTES_C,
  parameter int unsigned AW        = 11
) (
  input  logic          CLK_c,
  input  logic          RST_N_c,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [1:0]    ls_size,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          ls_done,
  output logic [31:0]   ls_rdata,
  output logic          ls_err,
  output logic [AW-1:0] ram_raddr,
  output logic          ram_re,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  state_t        state, state_nxt;
  logic          last_ls, grant_ls, we_r, err_r;
  logic [AW-1:0] addr_r, beat_addr;
  logic [31:0]   wdata_r, asm_rdata;
  logic [2:0]    n_r, beat_k;
  logic          last_cap, any_req;

  logic          pick_ls, acc_err;
  logic [AW-1:0] acc_addr;
  size_t         acc_size;
  logic [2:0]    acc_n;
  logic [AW:0]   acc_end;

  // Accept-time decode: round-robin pick, beat count and range check.
  always_comb begin
    any_req  = if_req || ls_req;
    pick_ls  = ls_req && (!if_req || !last_ls);
    acc_addr = pick_ls ? ls_addr : if_addr;
    acc_size = pick_ls ? size_t'(ls_size) : SZ_WORD;
    acc_n    = beat_count(acc_size);
    acc_end  = {1'b0, acc_addr} + (AW+1)'(acc_n) - (AW+1)'(1);
    acc_err  = (acc_end >= (AW+1)'(MEM_BYTES)) || (acc_size == SZ_ILL);
  end

  // State register.
  always_ff @(posedge CLK_c) begin
    if (!RST_N_c) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = acc_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (beat_k == (n_r - 3'd1)) state_nxt = we_r ? ST_RESP : ST_DRAIN;
      ST_DRAIN: if (last_cap) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Access context: latched on accept, beat counter, last-grant bookkeeping.
  always_ff @(posedge CLK_c) begin
    if (!RST_N_c) begin
      last_ls  <= 1'b0;
      grant_ls <= 1'b0;
      we_r     <= 1'b0;
      err_r    <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      n_r      <= '0;
      beat_k   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          beat_k <= '0;
          if (any_req) begin
            grant_ls <= pick_ls;
            addr_r   <= acc_addr;
            we_r     <= pick_ls && ls_we;
            wdata_r  <= ls_wdata;
            n_r      <= acc_n;
            err_r    <= acc_err;
          end
        end
        ST_ISSUE: beat_k  <= beat_k + 3'd1;
        ST_RESP:  last_ls <= grant_ls;
        default: ;
      endcase
    end
  end

  // Output decode: RAM beats in ISSUE, done/data/err in RESP.
  always_comb begin
    beat_addr = addr_r + AW'(beat_k);
    ram_re    = 1'b0;
    ram_raddr = '0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if_done   = 1'b0;
    if_rdata  = '0;
    if_err    = 1'b0;
    ls_done   = 1'b0;
    ls_rdata  = '0;
    ls_err    = 1'b0;
    case (state)
      ST_ISSUE: begin
        if (we_r) begin
          ram_we    = 1'b1;
          ram_waddr = beat_addr;
          ram_wdata = wdata_r[{beat_k[1:0], 3'b000} +: 8];
        end else begin
          ram_re    = 1'b1;
          ram_raddr = beat_addr;
        end
      end
      ST_RESP: begin
        if (grant_ls) begin
          ls_done  = 1'b1;
          ls_err   = err_r;
          ls_rdata = err_r ? '0 : asm_rdata;
        end else begin
          if_done  = 1'b1;
          if_err   = err_r;
          if_rdata = err_r ? '0 : asm_rdata;
        end
      end
      default: ;
    endcase
  end

  mem_beat_assembler #(
    .RD_LAT (RD_LAT)
  ) u_asm (
    .CLK_c     (CLK_c),
    .RST_N_c   (RST_N_c),
    .clr       (state == ST_IDLE),
    .beat_re   (ram_re),
    .n_beats   (n_r),
    .ram_rdata (ram_rdata),
    .last_cap  (last_cap),
    .rdata     (asm_rdata)
  );

endmodule

// File: tb/tb_mem_byte_arbiter.sv
// Self-checking bench for mem_byte_arbiter (RD_LAT=1 main instance, RD_LAT=2 fetch-only instance).
module tb_mem_byte_arbiter;

  logic CLK_c = 1'b0;
  always #5 CLK_c = ~CLK_c;
  logic RST_N_c;

  logic        if_req, if_done, if_err, ls_req, ls_we, ls_done, ls_err;
  logic [10:0] if_addr, ls_addr, ram_raddr, ram_waddr;
  logic [31:0] if_rdata, ls_wdata, ls_rdata;
  logic [1:0]  ls_size;
  logic        ram_re, ram_we;
  logic [7:0]  ram_wdata, ram_rdata;

  logic        b_if_req, b_if_done, b_if_err, b_ls_req, b_ls_we, b_ls_done, b_ls_err;
  logic [10:0] b_if_addr, b_ls_addr, b_ram_raddr, b_ram_waddr;
  logic [31:0] b_if_rdata, b_ls_wdata, b_ls_rdata;
  logic [1:0]  b_ls_size;
  logic        b_ram_re, b_ram_we;
  logic [7:0]  b_ram_wdata, b_ram_rdata, b_rd1;

  mem_byte_arbiter #(.RD_LAT(1)) u_dut (
    .CLK_c(CLK_c), .RST_N_c(RST_N_c),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_waddr(ram_waddr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_byte_arbiter #(.RD_LAT(2)) u_dut_l2 (
    .CLK_c(CLK_c), .RST_N_c(RST_N_c),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done), .if_rdata(b_if_rdata), .if_err(b_if_err),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_size(b_ls_size), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_done(b_ls_done), .ls_rdata(b_ls_rdata), .ls_err(b_ls_err),
    .ram_raddr(b_ram_raddr), .ram_re(b_ram_re), .ram_waddr(b_ram_waddr), .ram_we(b_ram_we),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // RAM environment: shared array, 1-cycle read for main DUT, 2-cycle for the second.
  logic [7:0] ram_mem [0:2047];
  bit         mem_loaded = 1'b0;
  always @(posedge CLK_c) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 2048; i++) ram_mem[i] <= 8'(i * 37 + 5);
      mem_loaded <= 1'b1;
    end else begin
      if (ram_re) ram_rdata <= ram_mem[ram_raddr];
      if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
      if (b_ram_re) b_rd1 <= ram_mem[b_ram_raddr];
      b_ram_rdata <= b_rd1;
    end
  end

  // Beat monitor on the main DUT's RAM port.
  logic [10:0] re_q[$];
  logic [18:0] we_q[$];
  bit          overlap = 1'b0;
  int          ls_done_cnt = 0;
  always @(posedge CLK_c) begin
    if (ram_re) re_q.push_back(ram_raddr);
    if (ram_we) we_q.push_back({ram_waddr, ram_wdata});
    if (ram_re && ram_we) overlap <= 1'b1;
    if (ls_done) ls_done_cnt <= ls_done_cnt + 1;
  end

  // Reference model state.
  logic [7:0] ref_mem [0:1535];
  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: beats, error, latency and result from the access rules.
  task automatic model_txn(input bit is_ls, input bit we, input logic [1:0] sz, input int addr,
                           input logic [31:0] wd, input int rdlat,
                           output int n, output bit err, output int lat, output logic [31:0] data);
    n    = !is_ls ? 4 : (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4));
    err  = (is_ls && sz == 2'd3) || (addr + n - 1 >= 1536);
    data = 32'h0;
    if (err) lat = 1;
    else if (is_ls && we) begin
      lat = n + 1;
      for (int k = 0; k < n; k++) ref_mem[addr + k] = wd[8*k +: 8];
    end else begin
      lat = n + rdlat + 1;
      for (int k = 0; k < n; k++) data[8*k +: 8] = ref_mem[addr + k];
    end
  endtask

  // Drive one request from cycle 0 (IDLE), wait for done, then return to an IDLE cycle.
  task automatic run_txn(input bit is_ls, input bit we, input logic [1:0] sz, input logic [10:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output bit other);
    lat = 0; rd = '0; er = 1'b0; other = 1'b0;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK_c); #1;
      if (c == 1) begin
        ls_addr = 11'($urandom); ls_wdata = $urandom; ls_size = 2'($urandom);
        ls_we = 1'($urandom); if_addr = 11'($urandom);
      end
      if (is_ls ? if_done : ls_done) other = 1'b1;
      if (is_ls ? ls_done : if_done) begin
        lat = c;
        rd  = is_ls ? ls_rdata : if_rdata;
        er  = is_ls ? ls_err : if_err;
        break;
      end
    end
    ls_req = 1'b0; if_req = 1'b0;
    @(posedge CLK_c); #1;
  endtask

  // Both requests at once; each is dropped the cycle it completes.
  task automatic tie_round(input logic [10:0] ls_a, input logic [10:0] if_a,
                           output int ls_cyc, output int if_cyc,
                           output logic [31:0] ls_d, output logic [31:0] if_d);
    ls_cyc = 0; if_cyc = 0; ls_d = '0; if_d = '0;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = ls_a;
    if_req = 1'b1; if_addr = if_a;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK_c); #1;
      if (ls_done) begin ls_cyc = c; ls_d = ls_rdata; ls_req = 1'b0; end
      if (if_done) begin if_cyc = c; if_d = if_rdata; if_req = 1'b0; end
      if (ls_cyc != 0 && if_cyc != 0) break;
    end
    ls_req = 1'b0; if_req = 1'b0;
    @(posedge CLK_c); #1;
  endtask

  task automatic apply_reset();
    RST_N_c = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; b_if_req = 1'b0;
    repeat (3) @(posedge CLK_c);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({if_done, if_rdata, if_err, ls_done, ls_rdata, ls_err, ram_raddr, ram_re,
         ram_waddr, ram_we, ram_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_a: got nonzero outputs (re=%b we=%b done=%b/%b) required all 0",
               ram_re, ram_we, if_done, ls_done);
    end
    vectors++;
    if ({b_if_done, b_if_rdata, b_if_err, b_ls_done, b_ls_rdata, b_ls_err, b_ram_raddr, b_ram_re,
         b_ram_waddr, b_ram_we, b_ram_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_b: got nonzero outputs required all 0");
    end
    RST_N_c = 1'b1;
    @(posedge CLK_c); #1;
  endtask

  // Generic checked transaction used by the directed and random tests.
  task automatic check_txn(input string name, input bit is_ls, input bit we, input logic [1:0] sz,
                           input logic [10:0] addr, input logic [31:0] wd);
    int n, lat, exp_lat, re0, we0, exp_re, exp_we;
    bit err, other;
    logic [31:0] rd, exp_d;
    logic er;
    re0 = re_q.size(); we0 = we_q.size();
    run_txn(is_ls, we, sz, addr, wd, lat, rd, er, other);
    model_txn(is_ls, we, sz, int'(addr), wd, 1, n, err, exp_lat, exp_d);
    exp_we = (!err && is_ls && we) ? n : 0;
    exp_re = (!err && !(is_ls && we)) ? n : 0;
    vectors++;
    if (lat !== exp_lat) begin miscompares++; $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat); end
    vectors++;
    if (rd !== exp_d) begin miscompares++; $display("FAIL %s rdata: got %h required %h", name, rd, exp_d); end
    vectors++;
    if (er !== err) begin miscompares++; $display("FAIL %s err: got %b required %b", name, er, err); end
    vectors++;
    if (other !== 1'b0) begin miscompares++; $display("FAIL %s other_done: got 1 required 0", name); end
    vectors++;
    if (re_q.size() - re0 != exp_re || we_q.size() - we0 != exp_we) begin
      miscompares++;
      $display("FAIL %s beat_count: got re=%0d we=%0d required re=%0d we=%0d", name,
               re_q.size() - re0, we_q.size() - we0, exp_re, exp_we);
    end else begin
      for (int k = 0; k < exp_re; k++) begin
        vectors++;
        if (re_q[re0 + k] !== 11'(int'(addr) + k)) begin
          miscompares++;
          $display("FAIL %s re_addr[%0d]: got %h required %h", name, k, re_q[re0 + k], 11'(int'(addr) + k));
        end
      end
      for (int k = 0; k < exp_we; k++) begin
        vectors++;
        if (we_q[we0 + k] !== {11'(int'(addr) + k), wd[8*k +: 8]}) begin
          miscompares++;
          $display("FAIL %s we_beat[%0d]: got %h required %h", name, k, we_q[we0 + k],
                   {11'(int'(addr) + k), wd[8*k +: 8]});
        end
      end
    end
  endtask

  task automatic test_fetch();
    check_txn("init_word_write", 1'b1, 1'b1, 2'd2, 11'h010, 32'h44332211);
    check_txn("fetch_0x010", 1'b0, 1'b0, 2'd2, 11'h010, 32'h0);
  endtask

  task automatic test_half_write();
    check_txn("half_write_5fe", 1'b1, 1'b1, 2'd1, 11'h5FE, 32'h1234BEEF);
    check_txn("byte_read_5ff", 1'b1, 1'b0, 2'd0, 11'h5FF, 32'h0);
  endtask

  task automatic test_range();
    check_txn("word_read_5fd_err", 1'b1, 1'b0, 2'd2, 11'h5FD, 32'h0);
    check_txn("size_11_err", 1'b1, 1'b0, 2'd3, 11'h020, 32'h0);
    check_txn("fetch_5fc_ok", 1'b0, 1'b0, 2'd2, 11'h5FC, 32'h0);
    check_txn("fetch_5fd_err", 1'b0, 1'b0, 2'd2, 11'h5FD, 32'h0);
  endtask

  task automatic test_arbitration();
    int lc, ic;
    logic [31:0] ld, id, exp_l, exp_i;
    apply_reset();
    RST_N_c = 1'b1;
    @(posedge CLK_c); #1;
    exp_l = {ref_mem[16'h103], ref_mem[16'h102], ref_mem[16'h101], ref_mem[16'h100]};
    exp_i = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
    for (int r = 0; r < 3; r++) begin
      if (r == 2) check_txn("ls_only_between_ties", 1'b1, 1'b0, 2'd0, 11'h040, 32'h0);
      tie_round(11'h100, 11'h000, lc, ic, ld, id);
      vectors++;
      if (lc != (r < 2 ? 6 : 13) || ic != (r < 2 ? 13 : 6)) begin
        miscompares++;
        $display("FAIL tie_order[%0d]: got ls=%0d if=%0d required ls=%0d if=%0d", r, lc, ic,
                 r < 2 ? 6 : 13, r < 2 ? 13 : 6);
      end
      vectors++;
      if (ld !== exp_l || id !== exp_i) begin
        miscompares++;
        $display("FAIL tie_data[%0d]: got ls=%h if=%h required ls=%h if=%h", r, ld, id, exp_l, exp_i);
      end
    end
  endtask

  task automatic test_reset_midwrite();
    int we0, d0;
    we0 = we_q.size(); d0 = ls_done_cnt;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 11'h200; ls_wdata = 32'hA1B2C3D4;
    @(posedge CLK_c); #1;
    @(posedge CLK_c); #1;
    RST_N_c = 1'b0;
    @(posedge CLK_c); #1;
    vectors++;
    if ({if_done, if_rdata, if_err, ls_done, ls_rdata, ls_err, ram_raddr, ram_re,
         ram_waddr, ram_we, ram_wdata} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got re=%b we=%b ls_done=%b required all 0", ram_re, ram_we, ls_done);
    end
    RST_N_c = 1'b1; ls_req = 1'b0;
    repeat (3) @(posedge CLK_c);
    #1;
    vectors++;
    if (we_q.size() - we0 != 2 || ls_done_cnt != d0) begin
      miscompares++;
      $display("FAIL midreset_beats: got writes=%0d dones=%0d required writes=2 dones=0",
               we_q.size() - we0, ls_done_cnt - d0);
    end
    ref_mem[16'h200] = 8'hD4;
    ref_mem[16'h201] = 8'hC3;
    check_txn("read_after_midreset", 1'b1, 1'b0, 2'd2, 11'h200, 32'h0);
  endtask

  task automatic test_random();
    bit is_ls, we;
    logic [1:0] sz;
    logic [10:0] a;
    int r;
    for (int i = 0; i < 60; i++) begin
      is_ls = ($urandom % 3) != 0;
      we    = is_ls && ($urandom % 2 == 1);
      r     = int'($urandom % 8);
      sz    = (r < 7) ? 2'(r % 3) : 2'd3;
      case ($urandom % 3)
        0:       a = 11'($urandom % 2048);
        1:       a = 11'(1528 + $urandom % 12);
        default: a = 11'($urandom % 1536);
      endcase
      check_txn("random", is_ls, we, sz, a, $urandom);
    end
    vectors++;
    if (overlap !== 1'b0) begin miscompares++; $display("FAIL re_we_overlap: got 1 required 0"); end
  endtask

  task automatic test_rdlat2();
    logic [10:0] a;
    int lat;
    logic [31:0] d, exp_d;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 11'h5FC : 11'($urandom % 1533);
      exp_d = {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
      b_if_req = 1'b1; b_if_addr = a; lat = 0; d = '0;
      for (int c = 1; c <= 40; c++) begin
        @(posedge CLK_c); #1;
        if (b_if_done) begin lat = c; d = b_if_rdata; break; end
      end
      b_if_req = 1'b0;
      @(posedge CLK_c); #1;
      vectors++;
      if (lat != 7 || d !== exp_d) begin
        miscompares++;
        $display("FAIL rdlat2_fetch[%h]: got lat=%0d data=%h required lat=7 data=%h", a, lat, d, exp_d);
      end
    end
  endtask

  initial begin
    RST_N_c = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0;
    b_ls_req = 1'b0; b_ls_we = 1'b0; b_ls_size = '0; b_ls_addr = '0; b_ls_wdata = '0;
    for (int i = 0; i < 1536; i++) ref_mem[i] = 8'(i * 37 + 5);
    @(posedge CLK_c); #1;
    test_reset();
    test_fetch();
    test_half_write();
    test_range();
    test_arbitration();
    test_reset_midwrite();
    test_random();
    test_rdlat2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
